// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32I immediate decoder feeding a small in-order output queue
//
// Purpose:
//   Decodes the immediate of a 32-bit RV32I instruction word (I, shift-amount I,
//   S, B, U, J; R gives 0) and sign-extends it to DATA_W. Each decoded result is
//   pushed into a DEPTH-entry FIFO so that fetch/decode and execute can stall
//   independently. A saturating counter records how many illegal words were
//   accepted.
//
// Parameters:
//   INST_W    - instruction width, fixed at 32
//   DATA_W    - immediate width, >= 32, sign-extended from inst_in[31]
//   DEPTH     - queue entries, power of two, >= 2
//   ILL_CNT_W - width of the illegal-instruction counter
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous queue clear, wins over accept and pop
//   in_valid     in   inst_in is valid
//   in_ready     out  queue has room (registered count only)
//   inst_in      in   instruction word
//   out_valid    out  head entry valid
//   out_ready    in   consumer takes the head entry
//   imm_out      out  head immediate (0 when empty)
//   fmt_out      out  head format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal
//   illegal_out  out  head entry is an illegal encoding
//   ill_cnt      out  saturating count of accepted illegal words

module imm_gen_pipe #(
    parameter int INST_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_W-1:0]    inst_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    imm_out,
    output logic [2:0]           fmt_out,
    output logic                 illegal_out,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [31:0]       w_imm32;
    logic [DATA_W-1:0] w_imm;
    logic [2:0]        w_fmt;
    logic              w_ill;
    logic [2:0]        w_funct3;

    assign w_funct3 = inst_in[14:12];

    // Every format is first assembled as a 32-bit signed value; the shift
    // amount case leaves bit 31 clear, so widening by bit 31 also covers zext.
    always_comb begin
        w_imm32 = 32'd0;
        w_fmt   = FMT_ILL;
        w_ill   = 1'b1;
        if (inst_in[1:0] == 2'b11) begin
            case (inst_in[6:0])
                OP_LOAD, OP_JALR, OP_SYSTEM: begin
                    w_imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
                    w_fmt   = FMT_I;
                    w_ill   = 1'b0;
                end
                OP_OPIMM: begin
                    // slli/srli/srai carry only a 5-bit shamt; bit 30 selects
                    // arithmetic vs logical and must not leak into the value.
                    if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                        w_imm32 = {27'd0, inst_in[24:20]};
                    end else begin
                        w_imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
                    end
                    w_fmt = FMT_I;
                    w_ill = 1'b0;
                end
                OP_STORE: begin
                    w_imm32 = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
                    w_fmt   = FMT_S;
                    w_ill   = 1'b0;
                end
                OP_BRANCH: begin
                    w_imm32 = {{19{inst_in[31]}}, inst_in[31], inst_in[7],
                               inst_in[30:25], inst_in[11:8], 1'b0};
                    w_fmt   = FMT_B;
                    w_ill   = 1'b0;
                end
                OP_LUI, OP_AUIPC: begin
                    w_imm32 = {inst_in[31:12], 12'd0};
                    w_fmt   = FMT_U;
                    w_ill   = 1'b0;
                end
                OP_JAL: begin
                    w_imm32 = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12],
                               inst_in[20], inst_in[30:21], 1'b0};
                    w_fmt   = FMT_J;
                    w_ill   = 1'b0;
                end
                OP_OP: begin
                    w_imm32 = 32'd0;
                    w_fmt   = FMT_R;
                    w_ill   = 1'b0;
                end
                default: begin
                    w_imm32 = 32'd0;
                    w_fmt   = FMT_ILL;
                    w_ill   = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_imm       = {DATA_W{w_imm32[31]}};
        w_imm[31:0] = w_imm32;
    end

    // ------------------------------------------------------------------
    // Output queue
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]    r_imm_q [DEPTH];
    logic [2:0]           r_fmt_q [DEPTH];
    logic                 r_ill_q [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    logic w_push;
    logic w_pop;

    // in_ready comes from the registered count only; gating with rst_n keeps
    // it low for the whole time reset is held.
    assign in_ready  = rst_n && (r_count < CNT_FULL);
    assign out_valid = (r_count != '0);

    // Flush suppresses both sides, so a dropped input never reaches the
    // storage or the illegal counter.
    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only visible through
    // out_valid, which is driven by the reset count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm_q[r_wr_ptr] <= w_imm;
            r_fmt_q[r_wr_ptr] <= w_fmt;
            r_ill_q[r_wr_ptr] <= w_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_cnt <= '0;
        end else if (w_push && w_ill && (r_ill_cnt != {ILL_CNT_W{1'b1}})) begin
            r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
        end
    end

    // Empty queue presents zeros rather than stale payload.
    assign imm_out     = out_valid ? r_imm_q[r_rd_ptr] : '0;
    assign fmt_out     = out_valid ? r_fmt_q[r_rd_ptr] : 3'd0;
    assign illegal_out = out_valid ? r_ill_q[r_rd_ptr] : 1'b0;
    assign ill_cnt     = r_ill_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe

module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;
    logic [2:0]  fmt_out;
    logic        illegal_out;
    logic [7:0]  ill_cnt;

    logic        flush64;
    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] inst_in64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] imm_out64;
    logic [2:0]  fmt_out64;
    logic        illegal_out64;
    logic [7:0]  ill_cnt64;

    int n_tests = 0;
    int n_fail  = 0;

    imm_gen_pipe #(.INST_W(32), .DATA_W(32), .DEPTH(4), .ILL_CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst_in(inst_in),
        .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out),
        .fmt_out(fmt_out), .illegal_out(illegal_out), .ill_cnt(ill_cnt)
    );

    imm_gen_pipe #(.INST_W(32), .DATA_W(64), .DEPTH(4), .ILL_CNT_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64), .inst_in(inst_in64),
        .out_valid(out_valid64), .out_ready(out_ready64), .imm_out(imm_out64),
        .fmt_out(fmt_out64), .illegal_out(illegal_out64), .ill_cnt(ill_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (imm_out !== 32'h0) begin n_fail++; $display("FAIL reset_imm: got %h expected 0", imm_out); end
        n_tests++; if (fmt_out !== 3'd0 || illegal_out !== 1'b0) begin n_fail++; $display("FAIL reset_fmt_ill: got %0d/%b expected 0/0", fmt_out, illegal_out); end
        n_tests++; if (ill_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ill_cnt: got %0d expected 0", ill_cnt); end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_load();
        in_valid = 1'b1; inst_in = 32'hFFC12083; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b expected 1", out_valid); end
        n_tests++; if (imm_out !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL load_imm: got %h expected FFFFFFFC", imm_out); end
        n_tests++; if (fmt_out !== 3'd1 || illegal_out !== 1'b0) begin n_fail++; $display("FAIL load_fmt: got %0d/%b expected 1/0", fmt_out, illegal_out); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || imm_out !== 32'h0) begin n_fail++; $display("FAIL load_drain: got %b/%h expected 0/0", out_valid, imm_out); end
    endtask

    task automatic test_branch_jump();
        out_ready = 1'b1;
        in_valid = 1'b1; inst_in = 32'hFE000CE3;
        tick();
        inst_in = 32'h001000EF;
        n_tests++; if (out_valid !== 1'b1 || imm_out !== 32'hFFFFFFF8 || fmt_out !== 3'd3) begin n_fail++; $display("FAIL beq: got %b/%h/%0d expected 1/FFFFFFF8/3", out_valid, imm_out, fmt_out); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || imm_out !== 32'h00000800 || fmt_out !== 3'd5) begin n_fail++; $display("FAIL jal: got %b/%h/%0d expected 1/00000800/5", out_valid, imm_out, fmt_out); end
        tick();
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bj_drain: got %b expected 0", out_valid); end
    endtask

    // Streaming table: with out_ready held high the head each cycle is the
    // word accepted at the previous edge.
    task automatic test_back_to_back();
        logic [31:0] insts [6];
        logic [31:0] imms  [6];
        logic [2:0]  fmts  [6];
        insts[0] = 32'h40335293; imms[0] = 32'h00000003; fmts[0] = 3'd1; // srai x5,x6,3
        insts[1] = 32'hFE112E23; imms[1] = 32'hFFFFFFFC; fmts[1] = 3'd2; // sw x1,-4(x2)
        insts[2] = 32'h800000B7; imms[2] = 32'h80000000; fmts[2] = 3'd4; // lui x1,0x80000
        insts[3] = 32'h00B50533; imms[3] = 32'h00000000; fmts[3] = 3'd0; // add x10,x10,x11
        insts[4] = 32'hFFF00093; imms[4] = 32'hFFFFFFFF; fmts[4] = 3'd1; // addi x1,x0,-1
        insts[5] = 32'hFFF09093; imms[5] = 32'h0000001F; fmts[5] = 3'd1; // slli x1,x1,31 with junk in [31:25]
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            inst_in = insts[i];
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || imm_out !== imms[i] || fmt_out !== fmts[i] || illegal_out !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %b/%h/%0d/%b expected 1/%h/%0d/0", i, out_valid, imm_out, fmt_out, illegal_out, imms[i], fmts[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_data_w64();
        out_ready64 = 1'b0;
        in_valid64 = 1'b1; inst_in64 = 32'hFFC12083;
        tick();
        inst_in64 = 32'h40335293;
        n_tests++; if (in_ready64 !== 1'b1) begin n_fail++; $display("FAIL w64_ready: got %b expected 1", in_ready64); end
        tick();
        in_valid64 = 1'b0;
        out_ready64 = 1'b1;
        n_tests++; if (out_valid64 !== 1'b1 || imm_out64 !== 64'hFFFFFFFFFFFFFFFC || fmt_out64 !== 3'd1) begin n_fail++; $display("FAIL w64_lw: got %b/%h/%0d expected 1/FFFFFFFFFFFFFFFC/1", out_valid64, imm_out64, fmt_out64); end
        tick();
        n_tests++; if (imm_out64 !== 64'h0000000000000003 || fmt_out64 !== 3'd1) begin n_fail++; $display("FAIL w64_srai: got %h/%0d expected 0000000000000003/1", imm_out64, fmt_out64); end
        tick();
        out_ready64 = 1'b0;
        n_tests++; if (out_valid64 !== 1'b0 || imm_out64 !== 64'h0) begin n_fail++; $display("FAIL w64_drain: got %b/%h expected 0/0", out_valid64, imm_out64); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_in = (32'(i + 1) << 20) | 32'h00000093; // addi x1,x0,i+1
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d: got %b expected 1", i, in_ready); end
            tick();
        end
        inst_in = (32'd5 << 20) | 32'h00000093;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_%0d: got %b expected 0", i, in_ready); end
            tick();
        end
        n_tests++; if (out_valid !== 1'b1 || imm_out !== 32'd1) begin n_fail++; $display("FAIL bp_head: got %b/%h expected 1/00000001", out_valid, imm_out); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reopen: got %b expected 1", in_ready); end
        n_tests++; if (imm_out !== 32'd2) begin n_fail++; $display("FAIL bp_order_1: got %h expected 00000002", imm_out); end
        tick();
        in_valid = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            n_tests++; if (out_valid !== 1'b1 || imm_out !== 32'(k)) begin n_fail++; $display("FAIL bp_order_%0d: got %b/%h expected 1/%h", k - 1, out_valid, imm_out, 32'(k)); end
            tick();
        end
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inst_in   = 32'h0000007F;
        tick();
        inst_in = 32'h00000000;
        n_tests++; if (out_valid !== 1'b1 || fmt_out !== 3'd7 || illegal_out !== 1'b1 || imm_out !== 32'h0) begin n_fail++; $display("FAIL ill_7f: got %b/%0d/%b/%h expected 1/7/1/0", out_valid, fmt_out, illegal_out, imm_out); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || fmt_out !== 3'd7 || illegal_out !== 1'b1 || imm_out !== 32'h0) begin n_fail++; $display("FAIL ill_00: got %b/%0d/%b/%h expected 1/7/1/0", out_valid, fmt_out, illegal_out, imm_out); end
        tick();
        out_ready = 1'b0;
        n_tests++; if (ill_cnt !== 8'd2) begin n_fail++; $display("FAIL ill_cnt_2: got %0d expected 2", ill_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_in = (32'(i + 10) << 20) | 32'h00000093;
            tick();
        end
        inst_in = 32'h00000000; // illegal: must be dropped and not counted
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm_out !== 32'h0) begin n_fail++; $display("FAIL flush_clear: got %b/%b/%h expected 0/1/0", out_valid, in_ready, imm_out); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b expected 0", out_valid); end
        n_tests++; if (ill_cnt !== 8'd2) begin n_fail++; $display("FAIL flush_ill_cnt: got %0d expected 2", ill_cnt); end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inst_in   = 32'h0000007F;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_tests++; if (ill_cnt !== 8'd255) begin n_fail++; $display("FAIL ill_saturate: got %0d expected 255", ill_cnt); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        inst_in  = 32'h00000000;
        tick();
        inst_in = 32'hFFC12083;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || fmt_out !== 3'd7 || illegal_out !== 1'b1) begin n_fail++; $display("FAIL refill_head: got %b/%0d/%b expected 1/7/1", out_valid, fmt_out, illegal_out); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || imm_out !== 32'h0 || fmt_out !== 3'd0 || illegal_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outs: got %b/%h/%0d/%b expected 0/0/0/0", out_valid, imm_out, fmt_out, illegal_out); end
        n_tests++; if (ill_cnt !== 8'd0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_cnt_ready: got %0d/%b expected 0/0", ill_cnt, in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_release: got %b/%b expected 1/0", in_ready, out_valid); end
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        inst_in     = 32'h0;
        out_ready   = 1'b0;
        flush64     = 1'b0;
        in_valid64  = 1'b0;
        inst_in64   = 32'h0;
        out_ready64 = 1'b0;

        test_reset();
        test_load();
        test_branch_jump();
        test_back_to_back();
        test_data_w64();
        test_backpressure();
        test_illegal();
        test_flush();
        test_saturate();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, buffered successor to the combinational immediate generator. It decodes every RV32I immediate format (I, S, B, U, J, and shift-amount I) from a 32-bit instruction word and sign-extends the result to `DATA_W`. Results are held in a small in-order output queue with valid/ready handshakes on both sides, so fetch/decode can stall independently of execute. It also keeps a saturating count of illegal encodings for debug.

## Interface
- `INST_W`, 32, instruction width; fixed at 32.
- `DATA_W`, 32, immediate output width; must be ≥ 32. Sign extension comes from `inst_in[31]`.
- `DEPTH`, 4, output queue entries; power of two, ≥ 2.
- `ILL_CNT_W`, 8, width of the illegal-instruction counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous queue clear.
- `in_valid`  in  1  `inst_in` is valid this cycle.
- `in_ready`  out  1  queue can accept an entry.
- `inst_in`  in  INST_W  instruction word.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer takes the head entry.
- `imm_out`  out  DATA_W  head immediate.
- `fmt_out`  out  3  head format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
- `illegal_out`  out  1  head entry is an illegal encoding.
- `ill_cnt`  out  ILL_CNT_W  saturating count of accepted illegal words.

## Operation
- Accept: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- Decode is combinational on `inst_in`. The decoded immediate, format and illegal flag are written into the queue tail on accept.
- Opcode `inst[6:0]` maps as follows:
  - `0000011`, `1100111`, `1110011`: I format, immediate `sext(inst[31:20])`.
  - `0010011` with funct3 `001`/`101`: I format, immediate `zext(inst[24:20])` (shamt only; `inst[30]` is excluded). Other funct3 values give `sext(inst[31:20])`.
  - `0100011`: S format, `sext({inst[31:25],inst[11:7]})`.
  - `1100011`: B format, `sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})`.
  - `0110111`, `0010111`: U format, `sext({inst[31:12],12'b0})`.
  - `1101111`: J format, `sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})`.
  - `0110011`: R format, immediate 0.
  - Anything else, including `inst[1:0] != 2'b11`: format 7, immediate 0, illegal flag 1.
- Queue: circular buffer with read/write pointers of width log2(`DEPTH`) plus an occupancy count of width log2(`DEPTH`)+1. Pointers wrap modulo `DEPTH`. Order is strictly FIFO.
- `in_ready = (count < DEPTH)`, derived from registered count only; it does not depend on `out_ready`.
- `out_valid = (count != 0)`.
- Empty queue: `imm_out`, `fmt_out`, `illegal_out` drive 0.
- Simultaneous accept and pop with 0 < count < `DEPTH`: count unchanged, both pointers advance.
- `ill_cnt` increments on each accept of an illegal word and saturates at all-ones. It is cleared only by reset, not by `flush`.
- `flush` (priority over accept and pop): count, pointers → 0. A same-cycle input is dropped and does not touch `ill_cnt`.

## Timing
- Reset (`rst_n` low, asynchronous, effective mid-operation):
  - count, pointers, `ill_cnt` → 0.
  - `out_valid`, `imm_out`, `fmt_out`, `illegal_out` → 0.
  - `in_ready` → 0 while `rst_n` is low, 1 from the first cycle after deassertion.
- Latency: a word accepted at edge N appears on the outputs after edge N (`out_valid` high in cycle N+1) when the queue was empty.
- Throughput: one accept and one pop per cycle in steady state.
- Full queue: the pop at edge N raises `in_ready` in cycle N+1. There is no same-cycle pass-through.
- Flush at edge N: `out_valid` = 0 and `in_ready` = 1 in cycle N+1.

## Test plan
- **Load immediate:** accept `0xFFC12083` (lw x1,-4(x2)) into an empty queue. Next cycle: `out_valid`=1, `imm_out`=`0xFFFFFFFC`, `fmt_out`=1, `illegal_out`=0.
- **Branch and jump reassembly:** push `0xFE000CE3` (beq x0,x0,-8) then `0x001000EF` (jal x1,2048) with `out_ready`=1. Expect `0xFFFFFFF8`/fmt 3, then `0x00000800`/fmt 5, on consecutive cycles.
- **Shift immediate:** `0x40335293` (srai x5,x6,3) → `imm_out`=`0x00000003`, fmt 1. Repeat with `DATA_W`=64 and `0xFFC12083` → `0xFFFFFFFFFFFFFFFC`.
- **Backpressure:** hold `out_ready`=0 and offer 5 words with `DEPTH`=4. `in_ready` drops after the 4th accept and the 5th is held. Release `out_ready`: all 5 emerge in order, and `in_ready` rises one cycle after the first pop.
- **Illegal counting:** accept `0x0000007F` and `0x00000000`. Both give fmt 7, `illegal_out`=1, immediate 0, and `ill_cnt` ends at 2. Force 300 illegal accepts with `ILL_CNT_W`=8: `ill_cnt` holds at 255.
- **Flush and reset mid-fill:** with 3 entries queued, assert `flush` together with `in_valid`. Next cycle `out_valid`=0 and the new word is absent. Refill, then pulse `rst_n` low between edges: all outputs go to 0 immediately and `ill_cnt`=0.
